// File: rtl/io_pkg.sv
// Shared constants for the writeback arbiter slice.
//   FifoDepth  - number of entries in the output buffer
//   ptr_width  - width of a channel index / round-robin pointer for n channels
package io_pkg;

    localparam int unsigned FifoDepth = 2;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Pointer-based round-robin search.
// Finds the first set bit of req, searching upward from ptr and wrapping
// from N-1 to 0.
//   req   - request vector
//   ptr   - search start position (always < N)
//   grant - one-hot grant (zero when no request)
//   idx   - index of the granted bit
//   found - any request present
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned PtrW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [PtrW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [PtrW-1:0] idx,
    output logic            found
);

    int unsigned j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = PtrW'(j);
            end
        end
    end

endmodule

// File: rtl/io_writeback_arbiter.sv
// Writeback arbiter: round-robin selection among PORTCOUNT source channels
// into a 2-entry {data, addr} FIFO feeding a single consumer.
// Optional macro IO_WBARB_PRIORITY_EN: channels in PRIORITYMASK win ahead of
// round-robin (lowest index first) and do not move the round-robin pointer.
// Ports:
//   sys_clk, async_rst (async, active high), clk_en (global enable)
//   InputACK/InputREQ/InputData/InputAddr - per-channel valid/accept/payload
//   OutputACK/OutputREQ/OutputData/OutputAddr - buffered output handshake
module io_writeback_arbiter
    import io_pkg::*;
#(
    parameter int unsigned          PORTCOUNT       = 14,
    parameter int unsigned          DATABITWIDTH    = 16,
    parameter int unsigned          REGADDRBITWIDTH = 4,
    parameter logic [PORTCOUNT-1:0] PRIORITYMASK    = '0
) (
    input  logic                                             sys_clk,
    input  logic                                             async_rst,
    input  logic                                             clk_en,
    input  logic [PORTCOUNT-1:0]                             InputACK,
    output logic [PORTCOUNT-1:0]                             InputREQ,
    input  logic [PORTCOUNT-1:0][DATABITWIDTH-1:0]           InputData,
    input  logic [PORTCOUNT-1:0][REGADDRBITWIDTH-1:0]        InputAddr,
    output logic                                             OutputACK,
    input  logic                                             OutputREQ,
    output logic [DATABITWIDTH-1:0]                          OutputData,
    output logic [REGADDRBITWIDTH-1:0]                       OutputAddr
);

    localparam int unsigned PtrW     = ptr_width(PORTCOUNT);
    localparam int unsigned CntW     = $clog2(FifoDepth + 1);
    localparam int unsigned FifoPtrW = $clog2(FifoDepth);

    logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [FifoPtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FifoDepth-1:0][DATABITWIDTH-1:0]    data_mem_q;
    logic [FifoDepth-1:0][REGADDRBITWIDTH-1:0] addr_mem_q;

    logic [PORTCOUNT-1:0] rr_grant, grant;
    logic [PtrW-1:0]      rr_idx, idx;
    logic                 rr_found, any_req, prio_hit;
    logic                 has_space, push, pop;

    rr_arbiter #(
        .N    (PORTCOUNT),
        .PtrW (PtrW)
    ) u_rr_arbiter (
        .req   (InputACK),
        .ptr   (rr_ptr_q),
        .grant (rr_grant),
        .idx   (rr_idx),
        .found (rr_found)
    );

`ifdef IO_WBARB_PRIORITY_EN
    logic [PORTCOUNT-1:0] prio_req, prio_grant;
    logic [PtrW-1:0]      prio_idx;

    assign prio_req = InputACK & PRIORITYMASK;

    // Downward scan so the lowest requesting index wins.
    always_comb begin
        prio_grant = '0;
        prio_idx   = '0;
        for (int i = PORTCOUNT - 1; i >= 0; i--) begin
            if (prio_req[i]) begin
                prio_grant    = '0;
                prio_grant[i] = 1'b1;
                prio_idx      = PtrW'(i);
            end
        end
    end

    always_comb begin
        grant    = rr_grant;
        idx      = rr_idx;
        any_req  = rr_found;
        prio_hit = 1'b0;
        if (|prio_req) begin
            grant    = prio_grant;
            idx      = prio_idx;
            prio_hit = 1'b1;
        end
    end
`else
    logic unused_prio_mask;
    assign unused_prio_mask = ^PRIORITYMASK;

    always_comb begin
        grant    = rr_grant;
        idx      = rr_idx;
        any_req  = rr_found;
        prio_hit = 1'b0;
    end
`endif

    // Acceptance depends only on registered count, never on OutputREQ, so a
    // full buffer blocks inputs even in a cycle that pops.
    assign has_space = (count_q != CntW'(FifoDepth));
    assign InputREQ  = (clk_en && has_space) ? grant : '0;
    assign push      = clk_en && has_space && any_req;
    assign pop       = clk_en && (count_q != '0) && OutputREQ;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push && !prio_hit) begin
            rr_ptr_d = (idx == PtrW'(PORTCOUNT - 1)) ? '0 : idx + 1'b1;
        end
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk or posedge async_rst) begin
        if (async_rst) begin
            rr_ptr_q   <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_mem_q <= '0;
            addr_mem_q <= '0;
        end else if (clk_en) begin
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            if (push) begin
                data_mem_q[wr_ptr_q] <= InputData[idx];
                addr_mem_q[wr_ptr_q] <= InputAddr[idx];
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign OutputACK  = (count_q != '0);
    assign OutputData = data_mem_q[rd_ptr_q];
    assign OutputAddr = addr_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_io_writeback_arbiter.sv
// Directed self-checking bench for io_writeback_arbiter (default parameters,
// PRIORITYMASK = 14'h0002 which only matters with IO_WBARB_PRIORITY_EN).
module tb_io_writeback_arbiter;

    localparam int unsigned PC = 14;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;

    logic                   sys_clk = 1'b0;
    logic                   async_rst;
    logic                   clk_en;
    logic [PC-1:0]          InputACK;
    logic [PC-1:0]          InputREQ;
    logic [PC-1:0][DW-1:0]  InputData;
    logic [PC-1:0][AW-1:0]  InputAddr;
    logic                   OutputACK;
    logic                   OutputREQ;
    logic [DW-1:0]          OutputData;
    logic [AW-1:0]          OutputAddr;

    int errors = 0;
    int checks = 0;

    io_writeback_arbiter #(
        .PORTCOUNT       (PC),
        .DATABITWIDTH    (DW),
        .REGADDRBITWIDTH (AW),
        .PRIORITYMASK    (14'h0002)
    ) dut (
        .sys_clk    (sys_clk),
        .async_rst  (async_rst),
        .clk_en     (clk_en),
        .InputACK   (InputACK),
        .InputREQ   (InputREQ),
        .InputData  (InputData),
        .InputAddr  (InputAddr),
        .OutputACK  (OutputACK),
        .OutputREQ  (OutputREQ),
        .OutputData (OutputData),
        .OutputAddr (OutputAddr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [31:0] bit_of(input int n);
        return 32'(1) << n;
    endfunction

    initial begin
        async_rst = 1'b1;
        clk_en    = 1'b1;
        InputACK  = '0;
        OutputREQ = 1'b0;
        for (int i = 0; i < PC; i++) begin
            InputData[i] = DW'(16'hA000 + i);
            InputAddr[i] = AW'(i);
        end

        // Reset state
        #12;
        check("rst_oack", 32'(OutputACK), 32'h0);
        check("rst_ireq", 32'(InputREQ), 32'h0);
        check("rst_rrptr", 32'(dut.rr_ptr_q), 32'h0);
        check("rst_odata", 32'(OutputData), 32'h0);
        check("rst_oaddr", 32'(OutputAddr), 32'h0);
        async_rst = 1'b0;

        // Round robin over channels 3, 5, 12 with a ready consumer
        InputACK  = 14'(1 << 3) | 14'(1 << 5) | 14'(1 << 12);
        OutputREQ = 1'b1;
        #1;
        check("rr_req0", 32'(InputREQ), bit_of(3));
        tick;
        check("rr_oack1", 32'(OutputACK), 32'h1);
        check("rr_data1", 32'(OutputData), 32'hA003);
        check("rr_addr1", 32'(OutputAddr), 32'h3);
        check("rr_req1", 32'(InputREQ), bit_of(5));
        tick;
        check("rr_data2", 32'(OutputData), 32'hA005);
        check("rr_req2", 32'(InputREQ), bit_of(12));
        tick;
        check("rr_data3", 32'(OutputData), 32'hA00C);
        check("rr_addr3", 32'(OutputAddr), 32'hC);
        check("rr_req3", 32'(InputREQ), bit_of(3));
        tick;
        check("rr_data4", 32'(OutputData), 32'hA003);
        check("rr_cnt4", 32'(dut.count_q), 32'h1);
        InputACK = '0;
        tick;
        check("rr_drain", 32'(OutputACK), 32'h0);
        check("rr_ptr_after", 32'(dut.rr_ptr_q), 32'h4);

        // Fill the FIFO from channel 0 with the consumer stalled
        OutputREQ    = 1'b0;
        InputACK     = 14'h0001;
        InputData[0] = 16'h1111;
        InputAddr[0] = 4'h1;
        #1;
        check("fill_req_wrap", 32'(InputREQ), bit_of(0));
        tick;
        check("fill_data1", 32'(OutputData), 32'h1111);
        InputData[0] = 16'h2222;
        InputAddr[0] = 4'h2;
        tick;
        check("full_cnt", 32'(dut.count_q), 32'h2);
        check("full_ireq", 32'(InputREQ), 32'h0);
        check("full_head", 32'(OutputData), 32'h1111);
        tick;
        check("full_hold", 32'(dut.count_q), 32'h2);
        // Full with ready consumer: pop but no push this cycle
        OutputREQ = 1'b1;
        #1;
        check("full_pop_noreq", 32'(InputREQ), 32'h0);
        tick;
        check("full_pop_cnt", 32'(dut.count_q), 32'h1);
        check("full_pop_data", 32'(OutputData), 32'h2222);
        check("full_pop_addr", 32'(OutputAddr), 32'h2);
        check("full_reopen", 32'(InputREQ), bit_of(0));
        InputACK = '0;
        tick;
        check("fill_drain", 32'(OutputACK), 32'h0);

        // Clock enable low freezes everything
        clk_en       = 1'b0;
        InputACK     = 14'(1 << 7);
        InputData[7] = 16'h7777;
        #1;
        check("ce_noreq", 32'(InputREQ), 32'h0);
        tick;
        check("ce_nopush", 32'(OutputACK), 32'h0);
        clk_en = 1'b1;
        #1;
        check("ce_req", 32'(InputREQ), bit_of(7));
        tick;
        check("ce_data", 32'(OutputData), 32'h7777);
        clk_en   = 1'b0;
        InputACK = '0;
        tick;
        check("ce_nopop", 32'(OutputACK), 32'h1);
        check("ce_ptr_frozen", 32'(dut.rr_ptr_q), 32'h8);
        clk_en = 1'b1;
        tick;
        check("ce_pop", 32'(OutputACK), 32'h0);

        // Reset mid-operation with one entry buffered
        OutputREQ    = 1'b0;
        InputACK     = 14'(1 << 2);
        InputData[2] = 16'h5A5A;
        InputAddr[2] = 4'h5;
        tick;
        check("mrst_pre", 32'(OutputACK), 32'h1);
        InputACK = '0;
        #1;
        async_rst = 1'b1;
        #1;
        check("mrst_oack", 32'(OutputACK), 32'h0);
        check("mrst_odata", 32'(OutputData), 32'h0);
        check("mrst_ireq", 32'(InputREQ), 32'h0);
        #1;
        async_rst = 1'b0;
        tick;
        check("mrst_lost", 32'(OutputACK), 32'h0);
        // Pointer restarts at 0: channel 2 beats 13
        InputACK = 14'(1 << 2) | 14'(1 << 13);
        #1;
        check("mrst_restart", 32'(InputREQ), bit_of(2));
        InputACK = '0;
        tick;

`ifdef IO_WBARB_PRIORITY_EN
        // Channel 1 is high priority; channel 7 never gets through first
        tick;
        OutputREQ = 1'b1;
        InputACK  = 14'(1 << 1) | 14'(1 << 7);
        #1;
        check("prio_req0", 32'(InputREQ), bit_of(1));
        tick;
        check("prio_data0", 32'(OutputData), 32'hA001);
        check("prio_req1", 32'(InputREQ), bit_of(1));
        tick;
        check("prio_req2", 32'(InputREQ), bit_of(1));
        check("prio_ptr", 32'(dut.rr_ptr_q), 32'h0);
        InputACK = '0;
        tick;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_writeback_arbiter.md
IO_WRITEBACK_ARBITER -- requirements
Module: io_writeback_arbiter

Interface
REQ-001 SHALL have parameter PORTCOUNT, default 14, meaning the number of writeback source channels (2..32).
REQ-002 SHALL have parameter DATABITWIDTH, default 16, meaning the writeback data width.
REQ-003 SHALL have parameter REGADDRBITWIDTH, default 4, meaning the destination register tag width.
REQ-004 SHALL have parameter PRIORITYMASK, default '0 (PORTCOUNT bits), meaning the channels treated as high priority when REQ-030 is compiled in.
REQ-005 SHALL have port sys_clk, input, 1 bit, the single clock (one clock domain).
REQ-006 SHALL have port async_rst, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port clk_en, input, 1 bit, global clock enable.
REQ-008 SHALL have port InputACK, input, [PORTCOUNT-1:0], per-channel valid.
REQ-009 SHALL have port InputREQ, output, [PORTCOUNT-1:0], per-channel accept.
REQ-010 SHALL have port InputData, input, [PORTCOUNT-1:0][DATABITWIDTH-1:0], per-channel data.
REQ-011 SHALL have port InputAddr, input, [PORTCOUNT-1:0][REGADDRBITWIDTH-1:0], per-channel destination register.
REQ-012 SHALL have port OutputACK, output, 1 bit, output valid.
REQ-013 SHALL have port OutputREQ, input, 1 bit, consumer ready.
REQ-014 SHALL have port OutputData, output, DATABITWIDTH bits, buffered data.
REQ-015 SHALL have port OutputAddr, output, REGADDRBITWIDTH bits, buffered destination register.

Function
REQ-016 SHALL complete a transfer on any port in a cycle where clk_en is high, ACK is high and REQ is high.
REQ-017 SHALL arbitrate round-robin: the grant goes to the first channel with InputACK high, searching upward from RRPointer and wrapping from PORTCOUNT-1 to 0.
REQ-018 SHALL drive InputREQ one-hot on the granted channel only when the buffer count is below 2 and clk_en is high; otherwise InputREQ SHALL be all zero.
REQ-019 SHALL derive InputREQ only from registered state and InputACK, never from OutputREQ.
REQ-020 SHALL set RRPointer to (granted index + 1) mod PORTCOUNT on each input transfer, and leave it unchanged otherwise.
REQ-021 SHALL hold accepted {data, addr} pairs in a 2-entry FIFO and present the head on OutputData and OutputAddr.
REQ-022 SHALL drive OutputACK high exactly when the FIFO count is nonzero.
REQ-023 SHALL accept an input in cycle N and make it visible on the output in cycle N+1, giving 1-cycle latency when the FIFO is empty.
REQ-024 SHALL, on a simultaneous push and pop, keep the count unchanged and preserve order.
REQ-025 SHALL withhold every InputREQ when the count is 2, even if OutputREQ is high that cycle.
REQ-026 SHALL, when clk_en is low, freeze all state and hold InputREQ at zero; OutputACK holds its value, but no pop occurs.
REQ-027 SHALL ignore a channel that drops InputACK before it is granted; there is no latching of unaccepted requests.

Reset
REQ-028 SHALL, on async_rst, immediately clear the count, the FIFO pointers and RRPointer, drive OutputACK to 0 and InputREQ to 0, and set OutputData and OutputAddr to 0.
REQ-029 SHALL discard in-flight FIFO contents on a reset asserted mid-operation; after release, arbitration restarts at channel 0.

Configuration
REQ-030 SHALL, with IO_WBARB_PRIORITY_EN defined, grant the lowest-index requesting channel in PRIORITYMASK ahead of round-robin, leaving RRPointer unchanged on priority grants; without the macro, PRIORITYMASK SHALL be ignored and arbitration SHALL be pure round-robin.

Structure
REQ-031 SHALL take the FIFO depth constant (2) and the pointer width function ($clog2(PORTCOUNT)) from the shared package io_pkg.
REQ-032 SHALL implement the pointer-based search as the sub-module rr_arbiter (request vector and pointer in, one-hot grant and index out).

Verification
REQ-033 SHALL cover: reset with all InputACK=0 -> OutputACK=0, InputREQ=0, RRPointer=0.
REQ-034 SHALL cover: channels 3, 5 and 12 held valid with OutputREQ=1 -> grants in the order 3, 5, 12, 3, each output 1 cycle after its grant.
REQ-035 SHALL cover: OutputREQ=0 while channel 0 sends data 0x1111 then 0x2222 -> count 2, InputREQ=0; then OutputREQ=1 -> 0x1111 then 0x2222 in order.
REQ-036 SHALL cover: full FIFO with OutputREQ=1 -> one pop, no push that cycle, InputREQ asserted the next cycle.
REQ-037 SHALL cover: async_rst pulse while count=1 -> OutputACK=0 within the same cycle and the entry lost.
REQ-038 SHALL cover: with IO_WBARB_PRIORITY_EN and PRIORITYMASK=14'h0002, channels 1 and 7 both valid -> channel 1 always granted first.
